// File: rtl/prog_counter_sched.sv
// Shares one external programmable counter between NREQ requesters: arbitrate, load, count, read back.
// Define PROG_COUNTER_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module prog_counter_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_load_val,
  input  logic [NREQ*CNT_W-1:0] req_run_len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [CNT_W-1:0]      rsp_data,
  output logic                  busy,
  output logic                  cnt_load_e,
  output logic [CNT_W-1:0]      cnt_load_val,
  output logic                  cnt_out_e,
  input  logic [CNT_W-1:0]      cnt_data
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] load_arr [NREQ];
  logic [CNT_W-1:0] len_arr  [NREQ];
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [NREQ-1:0]  pick_oh;

`ifndef PROG_COUNTER_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  int unsigned      scan;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign load_arr[g] = req_load_val[g*CNT_W +: CNT_W];
    assign len_arr[g]  = req_run_len[g*CNT_W +: CNT_W];
  end

  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
`ifndef PROG_COUNTER_SCHED_FIXED_PRIO_EN
    scan    = 0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef PROG_COUNTER_SCHED_FIXED_PRIO_EN
      if (!found && req[IDX_W'(i)]) begin
        found = 1'b1;
        pick  = IDX_W'(i);
      end
`else
      // Scan upward from the pointer, wrapping without relying on NREQ being a power of two.
      scan = 32'(ptr) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && req[IDX_W'(scan)]) begin
        found = 1'b1;
        pick  = IDX_W'(scan);
      end
`endif
    end
    if (found) pick_oh[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      grant        <= '0;
      done         <= '0;
      rsp_data     <= '0;
      busy         <= 1'b0;
      cnt_load_e   <= 1'b0;
      cnt_load_val <= '0;
      cnt_out_e    <= 1'b0;
`ifndef PROG_COUNTER_SCHED_FIXED_PRIO_EN
      ptr          <= '0;
      idx          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state        <= S_LOAD;
            remaining    <= len_arr[pick];
            cnt_load_e   <= 1'b1;
            cnt_load_val <= load_arr[pick];
            grant        <= pick_oh;
            busy         <= 1'b1;
`ifndef PROG_COUNTER_SCHED_FIXED_PRIO_EN
            idx          <= pick;
`endif
          end
        end
        S_LOAD: begin
          cnt_load_e   <= 1'b0;
          cnt_load_val <= '0;
          if (remaining == '0) begin
            state     <= S_READ;
            cnt_out_e <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state     <= S_READ;
            cnt_out_e <= 1'b1;
          end
        end
        S_READ: begin
          cnt_out_e <= 1'b0;
          rsp_data  <= cnt_data;
          done      <= grant;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifndef PROG_COUNTER_SCHED_FIXED_PRIO_EN
          ptr   <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_counter_sched.md
Name: prog_counter_sched

Overview:
Scheduler that shares one 8-bit programmable counter (load/count/tristate-read) between NREQ requesters. Each requester supplies a load value and a run length. The block arbitrates between them and sequences the counter through load, count for run-length cycles, and read. It then returns the captured count to the winning requester. It sits between requester logic and the counter's load_e/out_e/load_val/out_data pins.

Parameters:
NREQ, 4, number of requesters; legal range 2..8
CNT_W, 8, counter, load-value and run-length width

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
req_load_val  in  NREQ*CNT_W  packed load values; requester i uses bits [i*CNT_W +: CNT_W]
req_run_len  in  NREQ*CNT_W  packed run lengths, same packing
grant  out  NREQ  one-hot; owner of the counter, valid from LOAD through DONE
done  out  NREQ  one-hot, one-cycle pulse for the owner in DONE
rsp_data  out  CNT_W  captured count; registered; holds until the next capture
busy  out  1  high in every state except IDLE
cnt_load_e  out  1  counter load enable
cnt_load_val  out  CNT_W  counter load value
cnt_out_e  out  1  counter output enable
cnt_data  in  CNT_W  counter output data

Behaviour:
- Counter contract (fixed):
  - Loads cnt_load_val on an edge where cnt_load_e=1; otherwise increments by 1 per clock, wrapping 2^CNT_W-1 -> 0.
  - cnt_data is valid in any cycle where cnt_out_e=1.
- Reset (async, any state, including mid-operation):
  - state=IDLE; grant, done, busy, cnt_load_e, cnt_out_e = 0.
  - cnt_load_val=0, rsp_data=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
- FSM states: IDLE, LOAD, RUN, READ, DONE.
- IDLE:
  - If req != 0, select the winner by round robin: search starts at pointer, wrapping upward.
  - Latch winner index, its load value V and run length L; go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD, one cycle:
  - cnt_load_e=1, cnt_load_val=V, grant[idx]=1.
  - Next state is RUN with remaining=L, or READ directly if L==0.
- RUN:
  - grant held; remaining decrements each cycle.
  - Leave for READ when remaining==1 at the edge, so RUN lasts exactly L cycles.
- READ, one cycle:
  - cnt_out_e=1; rsp_data <= cnt_data at the edge; go to DONE.
- DONE, one cycle:
  - done[idx]=1, grant[idx]=1.
  - Pointer <= (idx+1) mod NREQ; go to IDLE.
- Result arithmetic: rsp_data = (V + L) mod 2^CNT_W.
- Latency: request seen in IDLE -> done pulse L+3 cycles later (1 IDLE + 1 LOAD + L RUN + 1 READ).
- Back-to-back operation:
  - After DONE there is always one IDLE cycle before the next grant.
  - A requester that keeps req high after done is treated as a new request.
- Request changes after the IDLE decision:
  - A requester that drops req mid-operation is ignored; the operation completes and done still pulses.
  - Changes to req_load_val or req_run_len after latching have no effect.
- Simultaneous requests: exactly one grant; others wait, with no starvation under round robin.
- cnt_load_val is 0 outside LOAD.
- cnt_load_e and cnt_out_e are never high in the same cycle.

Optional Feature:
Macro: PROG_COUNTER_SCHED_FIXED_PRIO_EN
- Defined:
  - Fixed priority; the lowest-index active requester always wins.
  - Pointer logic is removed.
- Undefined (default): round-robin arbitration as specified above.

Test Plan:
- Reset mid-RUN: assert reset while in RUN -> same cycle, async: grant=0, busy=0, cnt_load_e=0; after release, IDLE; next req starts from requester 0.
- Single request: req=4'b0010, V=8'h10, L=5 -> cnt_load_e pulses 1 cycle with cnt_load_val=8'h10; cnt_out_e 5 cycles later; done=4'b0010 at L+3=8 cycles; rsp_data=8'h15.
- Wrap and zero length: V=8'hFE, L=3 -> rsp_data=8'h01; then V=8'h7A, L=0 -> LOAD directly to READ, rsp_data=8'h7A, done 3 cycles after the request.
- Round robin: req=4'b1111 held high, L=1 for all -> grant order 0,1,2,3,0; exactly one IDLE cycle between each DONE and the next LOAD.
- Withdrawn request: requester 2 granted, L=4, drops req in RUN -> operation completes, done[2] pulses, rsp_data=V+4.
- With PROG_COUNTER_SCHED_FIXED_PRIO_EN defined: req=4'b1010 held high -> requester 1 granted every time; requester 3 is never granted.
